// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer and its prescaler:
// FSM state encoding, default clock rate, prescaler width helper.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int CLK_PER_SEC_DEFAULT = 240;

    // Width of a counter that runs 0 .. clk_per_sec-1.
    function automatic int presc_w(input int clk_per_sec);
        return (clk_per_sec < 2) ? 1 : $clog2(clk_per_sec);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into 1-second intervals.
// Ports: clk, reset (sync, active-high), enable (count), clear (force 0),
//        wrap (high on the cycle where count == CLK_PER_SEC-1 while enabled).
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int CLK_PER_SEC = CLK_PER_SEC_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic wrap
);

    localparam int W = presc_w(CLK_PER_SEC);
    localparam logic [W-1:0] LAST = W'(CLK_PER_SEC - 1);

    logic [W-1:0] count;

    assign wrap = enable && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/timer_countdown.sv
// Countdown timer: start + seconds_in requests an N-second delay,
// answered by a one-cycle done pulse; tick_1s pulses each elapsed second.
// Ports: clk, reset (sync, active-high), start, seconds_in, abort,
//        busy, done, tick_1s, seconds_left (all outputs registered).
// Build option: TIMER_COUNTDOWN_RESTART_EN lets start retrigger in RUN.
module timer_countdown
    import timer_pkg::*;
#(
    parameter int CLK_PER_SEC = CLK_PER_SEC_DEFAULT,
    parameter int SEC_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SEC_W-1:0] seconds_in,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             tick_1s,
    output logic [SEC_W-1:0] seconds_left
);

`ifdef TIMER_COUNTDOWN_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    state_t           state;
    state_t           state_n;
    logic [SEC_W-1:0] secs_n;
    logic             tick_n;
    logic             presc_en;
    logic             presc_clr;
    logic             wrap;

    assign presc_en = (state == RUN);

    tick_prescaler #(
        .CLK_PER_SEC(CLK_PER_SEC)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .enable(presc_en),
        .clear (presc_clr),
        .wrap  (wrap)
    );

    always_comb begin
        state_n   = state;
        secs_n    = seconds_left;
        tick_n    = 1'b0;
        presc_clr = 1'b0;
        case (state)
            RUN: begin
                if (abort) begin
                    state_n   = IDLE;
                    secs_n    = '0;
                    presc_clr = 1'b1;
                end else if (RESTART && start) begin
                    // Retrigger: the running interval is dropped silently.
                    presc_clr = 1'b1;
                    if (seconds_in != '0) begin
                        secs_n = seconds_in;
                    end else begin
                        state_n = FINISH;
                        secs_n  = '0;
                    end
                end else if (wrap) begin
                    tick_n = 1'b1;
                    if (seconds_left == SEC_W'(1)) begin
                        state_n = FINISH;
                        secs_n  = '0;
                    end else begin
                        secs_n = seconds_left - SEC_W'(1);
                    end
                end
            end
            default: begin
                // IDLE and FINISH both accept a new request.
                state_n = IDLE;
                if (start && !abort) begin
                    if (seconds_in != '0) begin
                        state_n = RUN;
                        secs_n  = seconds_in;
                    end else begin
                        state_n = FINISH;
                        secs_n  = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            seconds_left <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            tick_1s      <= 1'b0;
        end else begin
            state        <= state_n;
            seconds_left <= secs_n;
            busy         <= (state_n == RUN);
            done         <= (state_n == FINISH);
            tick_1s      <= tick_n;
        end
    end

endmodule

// File: tb/tb_timer_countdown.sv
// Directed bench for timer_countdown: a CLK_PER_SEC=4 instance for
// protocol details and a default-rate instance for full-length timing.
module tb_timer_countdown;

    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          f_start, f_abort;
    logic [SW-1:0] f_secs;
    logic          f_busy, f_done, f_tick;
    logic [SW-1:0] f_left;
    logic          s_start, s_abort;
    logic [SW-1:0] s_secs;
    logic          s_busy, s_done, s_tick;
    logic [SW-1:0] s_left;

    int checks = 0;
    int errors = 0;
    int exp_k;

    always #5 clk = ~clk;

    timer_countdown #(
        .CLK_PER_SEC(4),
        .SEC_W      (SW)
    ) u_fast (
        .clk         (clk),
        .reset       (reset),
        .start       (f_start),
        .seconds_in  (f_secs),
        .abort       (f_abort),
        .busy        (f_busy),
        .done        (f_done),
        .tick_1s     (f_tick),
        .seconds_left(f_left)
    );

    timer_countdown #(
        .SEC_W(SW)
    ) u_slow (
        .clk         (clk),
        .reset       (reset),
        .start       (s_start),
        .seconds_in  (s_secs),
        .abort       (s_abort),
        .busy        (s_busy),
        .done        (s_done),
        .tick_1s     (s_tick),
        .seconds_left(s_left)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        f_start = 1'b0; f_abort = 1'b0; f_secs = '0;
        s_start = 1'b0; s_abort = 1'b0; s_secs = '0;

        // 1: reset, then idle
        repeat (3) step();
        chk("rst_busy", f_busy, 0);
        chk("rst_done", f_done, 0);
        chk("rst_left", f_left, 0);
        chk("rst_tick", f_tick, 0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("idle_busy%0d", i), f_busy, 0);
            chk($sformatf("idle_done%0d", i), f_done, 0);
            chk($sformatf("idle_left%0d", i), f_left, 0);
            chk($sformatf("idle_sbusy%0d", i), s_busy, 0);
        end

        // 2: 3-second countdown
        f_start = 1'b1; f_secs = 4'd3;
        step();
        f_start = 1'b0; f_secs = '0;
        chk("n3_busy0", f_busy, 1);
        chk("n3_left0", f_left, 3);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("n3_tick%0d", k), f_tick, (k % 4) == 0);
            chk($sformatf("n3_left%0d", k), f_left, 3 - k / 4);
            chk($sformatf("n3_done%0d", k), f_done, k == 12);
            chk($sformatf("n3_busy%0d", k), f_busy, k < 12);
        end
        step();
        chk("n3_done13", f_done, 0);
        chk("n3_tick13", f_tick, 0);
        chk("n3_busy13", f_busy, 0);

        // 3: zero-second request
        f_start = 1'b1; f_secs = 4'd0;
        step();
        f_start = 1'b0;
        chk("z_done", f_done, 1);
        chk("z_busy", f_busy, 0);
        chk("z_tick", f_tick, 0);
        step();
        chk("z_done1", f_done, 0);
        chk("z_busy1", f_busy, 0);

        // 4: abort at E+9 of a 5-second request
        f_start = 1'b1; f_secs = 4'd5;
        step();
        f_start = 1'b0;
        for (int k = 1; k <= 8; k++) step();
        chk("ab_left8", f_left, 3);
        f_abort = 1'b1;
        step();
        f_abort = 1'b0;
        chk("ab_busy", f_busy, 0);
        chk("ab_left", f_left, 0);
        chk("ab_tick", f_tick, 0);
        chk("ab_done", f_done, 0);
        for (int i = 0; i < 30; i++) begin
            step();
            chk($sformatf("ab_nodone%0d", i), f_done, 0);
            chk($sformatf("ab_nobusy%0d", i), f_busy, 0);
        end
        f_start = 1'b1; f_abort = 1'b1; f_secs = 4'd3;
        step();
        f_start = 1'b0; f_abort = 1'b0;
        chk("as_busy", f_busy, 0);
        chk("as_done", f_done, 0);
        step();
        chk("as_busy1", f_busy, 0);

        // 5a: back-to-back request accepted in FINISH
        f_start = 1'b1; f_secs = 4'd2;
        step();
        f_start = 1'b0;
        for (int k = 1; k <= 7; k++) step();
        step();
        chk("bb_done1", f_done, 1);
        f_start = 1'b1; f_secs = 4'd1;
        step();
        f_start = 1'b0;
        chk("bb_busy", f_busy, 1);
        chk("bb_left", f_left, 1);
        chk("bb_dlow", f_done, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("bb_done2_%0d", k), f_done, k == 4);
        end
        step();

        // 5b: start pulsed during RUN
        f_start = 1'b1; f_secs = 4'd2;
        step();
        f_start = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        f_start = 1'b1; f_secs = 4'd1;
`ifdef TIMER_COUNTDOWN_RESTART_EN
        exp_k = 9;
`else
        exp_k = 8;
`endif
        for (int k = 5; k <= 12; k++) begin
            step();
            f_start = 1'b0;
            chk($sformatf("rs_done%0d", k), f_done, k == exp_k);
        end

        // 6: full-rate 4-second request, then reset mid-count
        s_start = 1'b1; s_secs = 4'd4;
        step();
        s_start = 1'b0;
        chk("sl_busy0", s_busy, 1);
        for (int k = 1; k <= 960; k++) begin
            step();
            chk($sformatf("sl_done%0d", k), s_done, k == 960);
            chk($sformatf("sl_tick%0d", k), s_tick, (k % 240) == 0);
        end
        chk("sl_left", s_left, 0);
        step();
        chk("sl_done961", s_done, 0);

        s_start = 1'b1; s_secs = 4'd4;
        step();
        s_start = 1'b0;
        for (int k = 1; k <= 499; k++) step();
        chk("sr_left499", s_left, 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("sr_busy", s_busy, 0);
        chk("sr_done", s_done, 0);
        chk("sr_tick", s_tick, 0);
        chk("sr_left", s_left, 0);
        for (int i = 0; i < 1000; i++) begin
            step();
            chk($sformatf("sr_nodone%0d", i), s_done, 0);
            chk($sformatf("sr_nobusy%0d", i), s_busy, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
